crypto1_keystream: RTL and testbench

Crypto1 keystream generator: loads a 48-bit key into the cipher LFSR, optionally mixes a 48-bit input word (UID^nonce) into the feedback, and produces 1..48 keystream bits, one per cycle. The bits are delivered serially and also collected into a 48-bit word. It is the forward (encrypt) direction of the cipher that the attack cores invert. It produces the BITSTREAM words and the reference states used to stimulate and cross-check the attack top level. It is bit-exact with the team's software reference model.

---
 rtl/crypto1_if.sv | 25 ++
 rtl/crypto1_keystream.sv | 94 +++++++++
 tb/tb_crypto1_keystream.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/crypto1_if.sv
// Crypto1 keystream generator bus: key/run control in, serial and collected keystream out.
interface crypto1_if;
  logic [47:0] KEY;
  logic        LOAD;
  logic        START;
  logic [5:0]  NBITS;
  logic        IN_EN;
  logic [47:0] IN_WORD;
  logic        KS_BIT;
  logic        KS_VALID;
  logic [47:0] BITSTREAM;
  logic        DONE;
  logic        BUSY;
  logic [47:0] STATE;

  modport master (
    output KEY, LOAD, START, NBITS, IN_EN, IN_WORD,
    input  KS_BIT, KS_VALID, BITSTREAM, DONE, BUSY, STATE
  );

  modport slave (
    input  KEY, LOAD, START, NBITS, IN_EN, IN_WORD,
    output KS_BIT, KS_VALID, BITSTREAM, DONE, BUSY, STATE
  );
endinterface

// File: rtl/crypto1_keystream.sv
// Crypto1 forward keystream: one filter bit per cycle from the 48-bit LFSR, optional input-word mixing.
// START-to-first-bit is one cycle; LOAD/START are dropped (not queued) while BUSY.
module crypto1_keystream (
  input  logic     CLK,
  input  logic     RESETn,
  crypto1_if.slave bus
);
  localparam logic [15:0] LUT_A = 16'hF22C;
  localparam logic [15:0] LUT_B = 16'hD938;
  localparam logic [31:0] LUT_C = 32'hEC57E80A;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t      state, state_nxt;
  logic [47:0] lfsr;
  logic [47:0] in_word_q;
  logic [47:0] bitstream;
  logic [5:0]  k;
  logic [5:0]  cnt;
  logic        in_en_q;
  logic [19:0] x;
  logic [4:0]  sel;
  logic        ks;
  logic        fb;

  // Filter taps are the odd state bits S9..S47.
  always_comb begin
    x = '0;
    for (int i = 0; i < 20; i++) x[i] = lfsr[9 + 2*i];
  end

  assign sel = {LUT_A[x[3:0]], LUT_B[x[7:4]], LUT_A[x[11:8]],
                LUT_A[x[15:12]], LUT_B[x[19:16]]};
  assign ks  = LUT_C[sel];

  assign fb = lfsr[0]  ^ lfsr[5]  ^ lfsr[9]  ^ lfsr[10] ^ lfsr[12] ^ lfsr[14] ^
              lfsr[15] ^ lfsr[17] ^ lfsr[19] ^ lfsr[24] ^ lfsr[25] ^ lfsr[27] ^
              lfsr[29] ^ lfsr[35] ^ lfsr[39] ^ lfsr[41] ^ lfsr[42] ^ lfsr[43] ^
              (in_en_q & in_word_q[k]);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!bus.LOAD && bus.START) state_nxt = ST_RUN;
      ST_RUN:  if (k == cnt - 6'd1) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      lfsr      <= '0;
      in_word_q <= '0;
      bitstream <= '0;
      k         <= '0;
      cnt       <= '0;
      in_en_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // LOAD takes priority; a simultaneous START is discarded.
          if (bus.LOAD) begin
            lfsr <= bus.KEY;
          end else if (bus.START) begin
            cnt       <= (bus.NBITS == 6'd0 || bus.NBITS > 6'd48) ? 6'd48 : bus.NBITS;
            in_en_q   <= bus.IN_EN;
            in_word_q <= bus.IN_WORD;
            bitstream <= '0;
            k         <= '0;
          end
        end
        ST_RUN: begin
          bitstream[k] <= ks;
          lfsr         <= {fb, lfsr[47:1]};
          k            <= k + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.KS_VALID  = (state == ST_RUN);
  assign bus.KS_BIT    = (state == ST_RUN) & ks;
  assign bus.BITSTREAM = bitstream;
  assign bus.DONE      = (state == ST_DONE);
  assign bus.BUSY      = (state != ST_IDLE);
  assign bus.STATE     = lfsr;
endmodule

// File: tb/tb_crypto1_keystream.sv
// Directed bench for crypto1_keystream against a bit-serial reference of the cipher.
module tb_crypto1_keystream;
  localparam logic [47:0] TAPS = 48'h0E882B0AD621;
  localparam logic [47:0] K2   = 48'hA5C31F079E64;
  localparam logic [47:0] W2   = 48'h3C960F5AB2E1;
  localparam logic [47:0] K3   = 48'h123456789ABC;

  logic CLK = 1'b0;
  logic RESETn;
  crypto1_if bus ();

  crypto1_keystream dut (.CLK(CLK), .RESETn(RESETn), .bus(bus));

  always #5 CLK = ~CLK;

  int          ntests = 0;
  int          nfail  = 0;
  logic [63:0] cap;
  int          cap_n;
  logic [47:0] ms;
  logic [47:0] mbits;

  always @(negedge CLK) begin
    if (bus.KS_VALID && cap_n < 64) begin
      cap[cap_n] = bus.KS_BIT;
      cap_n++;
    end
  end

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ks(input logic [47:0] s);
    logic [15:0] fa = 16'hF22C;
    logic [15:0] fbl = 16'hD938;
    logic [31:0] fc = 32'hEC57E80A;
    logic [19:0] xv;
    logic [4:0]  idx;
    for (int i = 0; i < 20; i++) xv[i] = s[9 + 2*i];
    idx[4] = fa[xv[3:0]];
    idx[3] = fbl[xv[7:4]];
    idx[2] = fa[xv[11:8]];
    idx[1] = fa[xv[15:12]];
    idx[0] = fbl[xv[19:16]];
    return fc[idx];
  endfunction

  task automatic model_run(input int n, input logic en, input logic [47:0] w);
    logic fbit;
    mbits = '0;
    for (int i = 0; i < n; i++) begin
      mbits[i] = model_ks(ms);
      fbit     = (^(ms & TAPS)) ^ (en & w[i]);
      ms       = {fbit, ms[47:1]};
    end
  endtask

  task automatic do_load(input string tag, input logic [47:0] key);
    bus.KEY  = key;
    bus.LOAD = 1'b1;
    tick;
    bus.LOAD = 1'b0;
    ms = key;
    chk({tag, "_state"}, {16'h0, bus.STATE}, {16'h0, key});
  endtask

  task automatic run_check(input string tag, input logic [5:0] nb, input logic en,
                           input logic [47:0] w, input int n_exp, input bit poke);
    int cyc;
    cap_n = 0;
    cap   = '0;
    bus.NBITS   = nb;
    bus.IN_EN   = en;
    bus.IN_WORD = w;
    bus.START   = 1'b1;
    tick;
    bus.START   = 1'b0;
    bus.IN_EN   = 1'b0;
    bus.IN_WORD = '0;
    cyc = 1;
    model_run(n_exp, en, w);
    chk({tag, "_busy"}, {63'h0, bus.BUSY}, 64'h1);
    while (!bus.DONE && cyc < 200) begin
      if (poke && cyc == 5) begin
        bus.KEY   = 48'hFFFF0000FFFF;
        bus.LOAD  = 1'b1;
        bus.START = 1'b1;
        bus.NBITS = 6'd1;
      end else begin
        bus.LOAD  = 1'b0;
        bus.START = 1'b0;
      end
      tick;
      cyc++;
    end
    bus.LOAD  = 1'b0;
    bus.START = 1'b0;
    chk({tag, "_done_cycle"}, 64'(cyc), 64'(n_exp + 1));
    chk({tag, "_nbits"}, 64'(cap_n), 64'(n_exp));
    chk({tag, "_serial"}, cap, {16'h0, mbits});
    chk({tag, "_bitstream"}, {16'h0, bus.BITSTREAM}, {16'h0, mbits});
    chk({tag, "_state"}, {16'h0, bus.STATE}, {16'h0, ms});
    tick;
    chk({tag, "_idle"}, {63'h0, bus.BUSY}, 64'h0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ks_bit"}, {63'h0, bus.KS_BIT}, 64'h0);
    chk({tag, "_ks_valid"}, {63'h0, bus.KS_VALID}, 64'h0);
    chk({tag, "_bitstream"}, {16'h0, bus.BITSTREAM}, 64'h0);
    chk({tag, "_done"}, {63'h0, bus.DONE}, 64'h0);
    chk({tag, "_busy"}, {63'h0, bus.BUSY}, 64'h0);
    chk({tag, "_state"}, {16'h0, bus.STATE}, 64'h0);
  endtask

  initial begin
    RESETn      = 1'b0;
    bus.KEY     = '0;
    bus.LOAD    = 1'b0;
    bus.START   = 1'b0;
    bus.NBITS   = '0;
    bus.IN_EN   = 1'b0;
    bus.IN_WORD = '0;
    cap_n = 0;
    cap   = '0;
    ms    = '0;
    tick;
    tick;
    chk_zero("reset");
    RESETn = 1'b1;

    // All-zero key: filter and feedback both stay 0.
    do_load("zero_load", 48'h0);
    run_check("zero_run", 6'd48, 1'b0, 48'h0, 48, 1'b0);
    chk("zero_hand_bits", {16'h0, bus.BITSTREAM}, 64'h0);

    do_load("one_load", 48'h000000000001);
    run_check("one_run", 6'd48, 1'b0, 48'h0, 48, 1'b0);

    do_load("mix_load", K2);
    run_check("mix_run32", 6'd32, 1'b1, W2, 32, 1'b0);
    chk("mix_upper_zero", {48'h0, bus.BITSTREAM[47:32]}, 64'h0);
    run_check("cont_run16", 6'd16, 1'b0, 48'h0, 16, 1'b0);

    run_check("nbits0", 6'd0, 1'b0, 48'h0, 48, 1'b0);
    run_check("nbits1", 6'd1, 1'b0, 48'h0, 1, 1'b0);
    run_check("nbits60", 6'd60, 1'b1, W2, 48, 1'b0);

    // LOAD/START pulsed mid-run must not disturb the run or the state.
    run_check("busy_poke", 6'd48, 1'b0, 48'h0, 48, 1'b1);

    bus.KEY   = K3;
    bus.LOAD  = 1'b1;
    bus.START = 1'b1;
    bus.NBITS = 6'd4;
    tick;
    bus.LOAD  = 1'b0;
    bus.START = 1'b0;
    ms = K3;
    chk("ldst_state", {16'h0, bus.STATE}, {16'h0, K3});
    chk("ldst_busy", {63'h0, bus.BUSY}, 64'h0);
    tick;
    chk("ldst_busy2", {63'h0, bus.BUSY}, 64'h0);
    chk("ldst_valid", {63'h0, bus.KS_VALID}, 64'h0);

    // Reset during a run, then replay the same stream from bit 0.
    do_load("rst_load", K2);
    cap_n = 0;
    bus.NBITS = 6'd48;
    bus.START = 1'b1;
    tick;
    bus.START = 1'b0;
    repeat (20) tick;
    chk("rst_pre_busy", {63'h0, bus.BUSY}, 64'h1);
    #1 RESETn = 1'b0;
    #1;
    chk_zero("rst_mid");
    tick;
    tick;
    RESETn = 1'b1;
    ms = '0;
    do_load("rst_reload", K2);
    run_check("rst_replay", 6'd48, 1'b0, 48'h0, 48, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
